// File: rtl/speed_sel_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : speed_sel_sched_pkg
//  Description : Shared constants for the game-speed scheduler: FSM state
//                codes, divider select codes and a saturating level helper.
//  Revision    : 1.0  initial release
// ============================================================================
package speed_sel_sched_pkg;

   typedef logic [3:0] sel_t;

   // Scheduler state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RUN    = 3'd1;
   localparam logic [2:0] ST_HOLD   = 3'd2;
   localparam logic [2:0] ST_PAUSED = 3'd3;
   localparam logic [2:0] ST_OVER   = 3'd4;

   // Select codes understood by the modulated clock divider
   localparam sel_t C_IDLE_SEL  = 4'd0;
   localparam sel_t C_PAUSE_SEL = 4'd1;

   // Compare-then-add so the level can never wrap past the ceiling
   function automatic sel_t satInc(input sel_t lvl, input sel_t maxLvl);
      return (lvl < maxLvl) ? sel_t'(lvl + 4'd1) : lvl;
   endfunction

endpackage
`default_nettype wire

// File: rtl/speed_sel_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : speed_sel_sched_if
//  Description : Game-control / debug / divider bundle for the scheduler.
//                master = game controller side, slave = scheduler side.
//  Revision    : 1.0  initial release
// ============================================================================
interface speed_sel_sched_if;
   import speed_sel_sched_pkg::*;

   logic DivClk;
   logic Start;
   logic ScoreEvt;
   logic GameOver;
   logic Pause;
   logic DbgEn;
   sel_t DbgSel;
   sel_t SpeedSel;
   sel_t Level;
   logic Running;
   logic SelChg;

   modport master (
      output DivClk, Start, ScoreEvt, GameOver, Pause, DbgEn, DbgSel,
      input  SpeedSel, Level, Running, SelChg
   );

   modport slave (
      input  DivClk, Start, ScoreEvt, GameOver, Pause, DbgEn, DbgSel,
      output SpeedSel, Level, Running, SelChg
   );

endinterface
`default_nettype wire

// File: rtl/speed_sel_sched_tick_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : tick_edge_det
//  Description : One-flop history of the divider output and a single-cycle
//                pulse on each of its rising edges.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_edge_det (
   input  wire logic Clk,
   input  wire logic Rst,
   input  wire logic DivClk,
   output logic      Tick
);
   logic r_divClkQ;

   // Remember last cycle's divider level
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_divClkQ <= 1'b0;
      end else begin
         r_divClkQ <= DivClk;
      end
   end

   assign Tick = DivClk & ~r_divClkQ;

endmodule
`default_nettype wire

// File: rtl/speed_sel_sched.sv
`default_nettype none
// ============================================================================
//  Module      : speed_sel_sched
//  Description : Game-speed scheduler. Steps the divider select code through
//                start/run/pause/over phases, promotes the level every
//                EVTS_PER_LVL score events and enforces a dwell of
//                DWELL_TICKS divider edges between promotions.
//  Revision    : 1.0  initial release
// ============================================================================
module speed_sel_sched
   import speed_sel_sched_pkg::*;
#(
   parameter sel_t       START_LVL    = 4'd3,
   parameter sel_t       MAX_LVL      = 4'd12,
   parameter logic [7:0] EVTS_PER_LVL = 8'd8,
   parameter logic [7:0] DWELL_TICKS  = 8'd4,
   parameter sel_t       IDLE_SEL     = C_IDLE_SEL,
   parameter sel_t       PAUSE_SEL    = C_PAUSE_SEL
) (
   input  wire logic         Clk,
   input  wire logic         Rst,
   speed_sel_sched_if.slave  bus
);
   logic [2:0] r_state,    w_stateNxt;
   logic       r_resumeHold, w_resumeNxt;
   sel_t       r_level,    w_levelNxt;
   logic [7:0] r_scoreCnt, w_scoreNxt;
   logic [7:0] r_dwellCnt, w_dwellNxt;
   logic       r_pending,  w_pendNxt;
   sel_t       r_speedSel, w_selNxt;
   sel_t       r_selPrev;
   logic       r_selChg;

   logic       w_tick;
   logic       w_scoreWrap;
   logic [7:0] w_scoreInc;
   logic [7:0] w_dwellSum;

   tick_edge_det u_tickDet (
      .Clk    (Clk),
      .Rst    (Rst),
      .DivClk (bus.DivClk),
      .Tick   (w_tick)
   );

   assign w_scoreWrap = bus.ScoreEvt && (r_scoreCnt == EVTS_PER_LVL - 8'd1);
   assign w_scoreInc  = w_scoreWrap ? 8'd0 : r_scoreCnt + 8'd1;
   assign w_dwellSum  = r_dwellCnt + {7'd0, w_tick};

   // Phase sequencing, score counting and dwell-gated promotion
   always_comb begin
      w_stateNxt  = r_state;
      w_resumeNxt = r_resumeHold;
      w_levelNxt  = r_level;
      w_scoreNxt  = r_scoreCnt;
      w_dwellNxt  = r_dwellCnt;
      w_pendNxt   = r_pending;
      case (r_state)
         ST_IDLE: begin
            if (bus.Start) begin
               w_stateNxt = ST_RUN;
               w_levelNxt = START_LVL;
               w_scoreNxt = 8'd0;
               w_dwellNxt = 8'd0;
               w_pendNxt  = 1'b0;
            end
         end
         ST_RUN: begin
            if (bus.GameOver) begin
               w_stateNxt = ST_OVER;
            end else if (bus.Pause) begin
               w_stateNxt  = ST_PAUSED;
               w_resumeNxt = 1'b0;
            end else if (bus.ScoreEvt) begin
               w_scoreNxt = w_scoreInc;
               // At the ceiling the promotion is absorbed and RUN continues
               if (w_scoreWrap && (r_level < MAX_LVL)) begin
                  w_levelNxt = satInc(r_level, MAX_LVL);
                  w_stateNxt = ST_HOLD;
                  w_dwellNxt = 8'd0;
               end
            end
         end
         ST_HOLD: begin
            if (bus.GameOver) begin
               w_stateNxt = ST_OVER;
            end else if (bus.Pause) begin
               w_stateNxt  = ST_PAUSED;
               w_resumeNxt = 1'b1;
            end else begin
               if (bus.ScoreEvt) begin
                  w_scoreNxt = w_scoreInc;
               end
               // Only one promotion may queue behind the dwell window
               w_pendNxt  = r_pending | w_scoreWrap;
               w_dwellNxt = w_dwellSum;
               if (w_dwellSum >= DWELL_TICKS) begin
                  if (w_pendNxt && (r_level < MAX_LVL)) begin
                     w_levelNxt = satInc(r_level, MAX_LVL);
                     w_dwellNxt = 8'd0;
                  end else begin
                     w_stateNxt = ST_RUN;
                  end
                  w_pendNxt = 1'b0;
               end
            end
         end
         ST_PAUSED: begin
            if (bus.GameOver) begin
               w_stateNxt = ST_OVER;
            end else if (!bus.Pause) begin
               w_stateNxt = r_resumeHold ? ST_HOLD : ST_RUN;
            end
         end
         ST_OVER: begin
            if (bus.Start) begin
               w_stateNxt = ST_IDLE;
            end
         end
         default: begin
            w_stateNxt = ST_IDLE;
         end
      endcase
   end

   // Select code: debug override first, then phase-derived code
   always_comb begin
      w_selNxt = IDLE_SEL;
      if (bus.DbgEn) begin
         w_selNxt = bus.DbgSel;
      end else if (r_state == ST_PAUSED) begin
         w_selNxt = PAUSE_SEL;
      end else if ((r_state == ST_RUN) || (r_state == ST_HOLD)) begin
         w_selNxt = r_level;
      end
   end

   // Scheduler state registers
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state      <= ST_IDLE;
         r_resumeHold <= 1'b0;
         r_level      <= START_LVL;
         r_scoreCnt   <= 8'd0;
         r_dwellCnt   <= 8'd0;
         r_pending    <= 1'b0;
      end else begin
         r_state      <= w_stateNxt;
         r_resumeHold <= w_resumeNxt;
         r_level      <= w_levelNxt;
         r_scoreCnt   <= w_scoreNxt;
         r_dwellCnt   <= w_dwellNxt;
         r_pending    <= w_pendNxt;
      end
   end

   // Registered select plus a change pulse one cycle after it moves
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_speedSel <= IDLE_SEL;
         r_selPrev  <= IDLE_SEL;
         r_selChg   <= 1'b0;
      end else begin
         r_speedSel <= w_selNxt;
         r_selPrev  <= r_speedSel;
         r_selChg   <= (r_speedSel != r_selPrev);
      end
   end

   assign bus.SpeedSel = r_speedSel;
   assign bus.Level    = r_level;
   assign bus.Running  = (r_state == ST_RUN) || (r_state == ST_HOLD);
   assign bus.SelChg   = r_selChg;

endmodule
`default_nettype wire

// File: tb/tb_speed_sel_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_speed_sel_sched
//  Description : Self-checking bench for speed_sel_sched: a fixed vector
//                table, directed corner sequences and a randomized run
//                against a countdown-based behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_speed_sel_sched;
   import speed_sel_sched_pkg::*;

   logic Clk;
   logic Rst;
   int   nChecks;
   int   nFails;

   speed_sel_sched_if ifc ();

   speed_sel_sched dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (ifc)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- behavioural model ----------------
   localparam int P_IDLE = 0, P_RUN = 1, P_HOLD = 2, P_PAUSED = 3, P_OVER = 4;
   int mPhase, mLevel, mEvLeft, mTicksLeft, mSel, mSelPrev, mChg;
   bit mQueued, mResumeHold, mDivPrev;

   task automatic modelReset();
      mPhase = P_IDLE; mLevel = 3; mEvLeft = 8; mTicksLeft = 4;
      mSel = 0; mSelPrev = 0; mChg = 0;
      mQueued = 0; mResumeHold = 0; mDivPrev = 0;
   endtask

   task automatic modelStep();
      bit tick;
      int newSel;
      tick = ifc.DivClk && !mDivPrev;
      mDivPrev = ifc.DivClk;
      if (ifc.DbgEn)                              newSel = int'(ifc.DbgSel);
      else if (mPhase == P_PAUSED)                newSel = 1;
      else if (mPhase == P_RUN || mPhase == P_HOLD) newSel = mLevel;
      else                                        newSel = 0;
      mChg = (mSel != mSelPrev) ? 1 : 0;
      mSelPrev = mSel;
      mSel = newSel;
      case (mPhase)
         P_IDLE: if (ifc.Start) begin
            mPhase = P_RUN; mLevel = 3; mEvLeft = 8; mTicksLeft = 4; mQueued = 0;
         end
         P_RUN: begin
            if (ifc.GameOver) mPhase = P_OVER;
            else if (ifc.Pause) begin mPhase = P_PAUSED; mResumeHold = 0; end
            else if (ifc.ScoreEvt) begin
               mEvLeft--;
               if (mEvLeft == 0) begin
                  mEvLeft = 8;
                  if (mLevel < 12) begin mLevel++; mPhase = P_HOLD; mTicksLeft = 4; end
               end
            end
         end
         P_HOLD: begin
            if (ifc.GameOver) mPhase = P_OVER;
            else if (ifc.Pause) begin mPhase = P_PAUSED; mResumeHold = 1; end
            else begin
               if (tick) mTicksLeft--;
               if (ifc.ScoreEvt) begin
                  mEvLeft--;
                  if (mEvLeft == 0) begin mEvLeft = 8; mQueued = 1; end
               end
               if (mTicksLeft == 0) begin
                  if (mQueued && mLevel < 12) begin mLevel++; mTicksLeft = 4; end
                  else mPhase = P_RUN;
                  mQueued = 0;
               end
            end
         end
         P_PAUSED: begin
            if (ifc.GameOver) mPhase = P_OVER;
            else if (!ifc.Pause) mPhase = mResumeHold ? P_HOLD : P_RUN;
         end
         default: if (ifc.Start) mPhase = P_IDLE;
      endcase
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      modelStep();
      #1;
      chk("mdl.SpeedSel", int'(ifc.SpeedSel), mSel);
      chk("mdl.Level",    int'(ifc.Level),    mLevel);
      chk("mdl.Running",  int'(ifc.Running),  (mPhase == P_RUN || mPhase == P_HOLD) ? 1 : 0);
      chk("mdl.SelChg",   int'(ifc.SelChg),   mChg);
   endtask

   task automatic clearIn();
      ifc.DivClk = 0; ifc.Start = 0; ifc.ScoreEvt = 0; ifc.GameOver = 0;
      ifc.Pause = 0; ifc.DbgEn = 0; ifc.DbgSel = 4'd0;
   endtask

   task automatic doReset();
      clearIn();
      Rst = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      modelReset();
      Rst = 1'b1;
      chk("rst.SpeedSel", int'(ifc.SpeedSel), 0);
      chk("rst.Level",    int'(ifc.Level),    3);
      chk("rst.Running",  int'(ifc.Running),  0);
      chk("rst.SelChg",   int'(ifc.SelChg),   0);
   endtask

   task automatic scores(input int n);
      ifc.ScoreEvt = 1;
      repeat (n) step();
      ifc.ScoreEvt = 0;
   endtask

   task automatic divTick();
      ifc.DivClk = 1; step();
      ifc.DivClk = 0; step();
   endtask

   task automatic startGame();
      ifc.Start = 1; step();
      ifc.Start = 0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit st, sc, go, pa, de;
      int ds, eSel, eLvl, eRun, eChg;
   } vec_t;
   vec_t tbl[19];

   function automatic vec_t mk(bit st, bit sc, bit go, bit pa, bit de, int ds,
                               int eSel, int eLvl, int eRun, int eChg);
      vec_t v;
      v.st = st; v.sc = sc; v.go = go; v.pa = pa; v.de = de; v.ds = ds;
      v.eSel = eSel; v.eLvl = eLvl; v.eRun = eRun; v.eChg = eChg;
      return v;
   endfunction

   initial begin
      nChecks = 0;
      nFails  = 0;
      Rst     = 1'b0;
      clearIn();

      //           st sc go pa de ds   sel lvl run chg
      tbl[0]  = mk(0, 0, 0, 0, 0, 0,    0, 3, 0, 0);
      tbl[1]  = mk(1, 0, 0, 0, 0, 0,    0, 3, 1, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0,    3, 3, 1, 0);
      tbl[3]  = mk(0, 0, 0, 0, 0, 0,    3, 3, 1, 1);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0,    3, 3, 1, 0);
      tbl[5]  = mk(0, 0, 0, 1, 0, 0,    3, 3, 0, 0);
      tbl[6]  = mk(0, 0, 0, 1, 0, 0,    1, 3, 0, 0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0,    1, 3, 1, 1);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0,    3, 3, 1, 0);
      tbl[9]  = mk(0, 0, 0, 0, 1, 15,  15, 3, 1, 1);
      tbl[10] = mk(0, 0, 0, 0, 1, 15,  15, 3, 1, 1);
      tbl[11] = mk(0, 0, 0, 0, 0, 0,    3, 3, 1, 0);
      tbl[12] = mk(0, 0, 0, 0, 0, 0,    3, 3, 1, 1);
      tbl[13] = mk(0, 0, 1, 1, 0, 0,    3, 3, 0, 0);
      tbl[14] = mk(0, 0, 0, 0, 0, 0,    0, 3, 0, 0);
      tbl[15] = mk(0, 0, 0, 0, 0, 0,    0, 3, 0, 1);
      tbl[16] = mk(1, 0, 0, 0, 0, 0,    0, 3, 0, 0);
      tbl[17] = mk(1, 0, 0, 0, 0, 0,    0, 3, 1, 0);
      tbl[18] = mk(0, 0, 0, 0, 0, 0,    3, 3, 1, 0);

      doReset();
      for (int i = 0; i < 19; i++) begin
         ifc.Start = tbl[i].st; ifc.ScoreEvt = tbl[i].sc; ifc.GameOver = tbl[i].go;
         ifc.Pause = tbl[i].pa; ifc.DbgEn = tbl[i].de; ifc.DbgSel = 4'(tbl[i].ds);
         step();
         chk($sformatf("tbl%0d.SpeedSel", i), int'(ifc.SpeedSel), tbl[i].eSel);
         chk($sformatf("tbl%0d.Level", i),    int'(ifc.Level),    tbl[i].eLvl);
         chk($sformatf("tbl%0d.Running", i),  int'(ifc.Running),  tbl[i].eRun);
         chk($sformatf("tbl%0d.SelChg", i),   int'(ifc.SelChg),   tbl[i].eChg);
      end
      clearIn();

      // Promotion after 8 events, dwell of exactly 4 divider edges
      doReset();
      startGame();
      scores(8);
      chk("promo.Level", int'(ifc.Level), 4);
      chk("promo.hold",  int'(dut.r_state), int'(ST_HOLD));
      step();
      chk("promo.SpeedSel", int'(ifc.SpeedSel), 4);
      repeat (3) divTick();
      chk("dwell3.hold", int'(dut.r_state), int'(ST_HOLD));
      divTick();
      chk("dwell4.run",  int'(dut.r_state), int'(ST_RUN));

      // Two promotions inside one dwell window: only one is queued
      doReset();
      startGame();
      scores(8);
      scores(16);
      chk("pend.Level",   int'(ifc.Level), 4);
      chk("pend.flag",    int'(dut.r_pending), 1);
      repeat (4) divTick();
      chk("pend.Level5",  int'(ifc.Level), 5);
      chk("pend.rehold",  int'(dut.r_state), int'(ST_HOLD));
      repeat (4) divTick();
      chk("pend.final",   int'(ifc.Level), 5);
      chk("pend.run",     int'(dut.r_state), int'(ST_RUN));

      // Pause mid-dwell freezes the dwell count
      doReset();
      startGame();
      scores(8);
      repeat (2) divTick();
      ifc.Pause = 1; step();
      repeat (10) divTick();
      chk("pause.SpeedSel", int'(ifc.SpeedSel), 1);
      chk("pause.Running",  int'(ifc.Running), 0);
      ifc.Pause = 0; step();
      chk("resume.hold", int'(dut.r_state), int'(ST_HOLD));
      divTick();
      chk("resume1.hold", int'(dut.r_state), int'(ST_HOLD));
      divTick();
      chk("resume2.run", int'(dut.r_state), int'(ST_RUN));

      // Debug override hides promotion but the level still advances
      doReset();
      startGame();
      ifc.DbgEn = 1; ifc.DbgSel = 4'd15;
      scores(8);
      chk("dbg.SpeedSel", int'(ifc.SpeedSel), 15);
      chk("dbg.Level",    int'(ifc.Level), 4);
      ifc.DbgEn = 0; step();
      chk("dbg.off.SpeedSel", int'(ifc.SpeedSel), 4);

      // Asynchronous reset in the middle of a dwell window
      doReset();
      startGame();
      scores(8);
      #2 Rst = 1'b0;
      #1;
      chk("arst.SpeedSel", int'(ifc.SpeedSel), 0);
      chk("arst.Level",    int'(ifc.Level), 3);
      chk("arst.Running",  int'(ifc.Running), 0);
      chk("arst.SelChg",   int'(ifc.SelChg), 0);
      modelReset();
      clearIn();
      @(posedge Clk);
      #1 Rst = 1'b1;

      // Randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         ifc.Start    = ($urandom_range(0, 11) == 0);
         ifc.ScoreEvt = ($urandom_range(0, 1) == 1);
         ifc.GameOver = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 24) == 0) ifc.Pause = ~ifc.Pause;
         if ($urandom_range(0, 59) == 0) ifc.DbgEn = ~ifc.DbgEn;
         ifc.DbgSel = 4'($urandom_range(0, 15));
         ifc.DivClk = ($urandom_range(0, 2) == 0) ? ~ifc.DivClk : ifc.DivClk;
         step();
         if ($urandom_range(0, 499) == 0) begin
            #2 Rst = 1'b0;
            #1;
            chk("rnd.arst.SpeedSel", int'(ifc.SpeedSel), 0);
            chk("rnd.arst.Level",    int'(ifc.Level), 3);
            modelReset();
            @(posedge Clk);
            #1 Rst = 1'b1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/speed_sel_sched.md
Name: speed_sel_sched

Overview:
- Game-speed scheduler that drives the 4-bit speed-select input of the modulated clock divider.
- Sequences the speed level through start, run, pause and game-over phases, and promotes the level after a fixed number of score events.
- Enforces a minimum dwell, counted in divider output ticks, between promotions, because every select change restarts the divider.
- Arbitrates between game control and a debug override switch bank.

Parameters:
- START_LVL, 3: select code loaded on Start.
- MAX_LVL, 12: highest code reachable by promotion; saturates there.
- EVTS_PER_LVL, 8: score events per promotion, range 1..255.
- DWELL_TICKS, 4: divider rising edges required after a change before the next promotion, range 1..255.
- IDLE_SEL, 0: select code in IDLE and OVER.
- PAUSE_SEL, 1: select code while paused.

Ports:
- Clk, in, 1: system clock.
- Rst, in, 1: asynchronous, active-low reset.
- DivClk, in, 1: divider ClkOut, synchronous to Clk.
- Start, in, 1: one-cycle pulse, begin game.
- ScoreEvt, in, 1: one-cycle pulse per point.
- GameOver, in, 1: one-cycle pulse.
- Pause, in, 1: level; high requests pause.
- DbgEn, in, 1: debug override enable.
- DbgSel, in, 4: debug select code.
- SpeedSel, out, 4: registered; to divider In.
- Level, out, 4: current game level.
- Running, out, 1: high in RUN or HOLD.
- SelChg, out, 1: one-cycle pulse the cycle after SpeedSel changes value.

Behaviour:
- Reset (Rst low, async):
  - state=IDLE, Level=START_LVL, SpeedSel=IDLE_SEL.
  - Running=0, SelChg=0.
  - Score counter, dwell counter, pending flag and DivClk history all cleared.
- Tick detection: tick = DivClk & ~DivClk_q, where DivClk_q is a one-flop history register.
- States:
  - IDLE:
    - Start -> RUN; Level=START_LVL; dwell counter=0; score counter=0.
  - RUN:
    - GameOver -> OVER.
    - else Pause -> PAUSED, with resume target RUN.
    - else ScoreEvt increments the score counter. When the counter is at EVTS_PER_LVL-1, it wraps to 0 and the block promotes.
    - Promotion: Level=min(Level+1, MAX_LVL). If Level actually changes, go to HOLD with dwell counter=0. At MAX_LVL, stay in RUN with no change.
  - HOLD:
    - Each tick increments the dwell counter; when it reaches DWELL_TICKS -> RUN.
    - ScoreEvt still counts. A promotion arriving in HOLD sets the pending flag; the flag saturates at 1 and further promotions are dropped.
    - On HOLD -> RUN with pending set: clear pending and promote immediately in the same cycle, re-entering HOLD.
    - GameOver -> OVER, else Pause -> PAUSED with resume target HOLD. The dwell counter is frozen while paused.
  - PAUSED:
    - Ticks and ScoreEvt are ignored.
    - GameOver -> OVER.
    - Pause low -> resume target state.
  - OVER:
    - Start -> IDLE on the next cycle. A second Start is required to run.
- SpeedSel next value, in priority order:
  - DbgEn=1: DbgSel.
  - PAUSED: PAUSE_SEL.
  - IDLE or OVER: IDLE_SEL.
  - RUN or HOLD: Level.
- SpeedSel is registered, giving 1-cycle latency from a state or Level change.
- DbgEn does not stop the FSM. Level keeps advancing underneath, and deasserting DbgEn restores the Level-derived code.
- Simultaneous events, same cycle:
  - GameOver beats Pause, which beats ScoreEvt.
  - Start is ignored outside IDLE and OVER.
  - tick and promotion in the same HOLD cycle: the tick is counted first, then the exit check.
- Width rules:
  - Score and dwell counters are 8 bits.
  - Level is 4 bits and never exceeds MAX_LVL.
  - Promotion arithmetic is a 4-bit compare-then-add, with no wrap to 0.
- Reset mid-operation returns all outputs to reset values immediately, in any state including PAUSED.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=0, RUN=1, HOLD=2, PAUSED=3, OVER=4, 3 bits.
  - The select-code constants IDLE_SEL and PAUSE_SEL, shared with the divider.
- One sub-module, tick_edge_det: DivClk history flop plus the rising-edge pulse.
- Counters and the FSM stay in the top module.

Test Plan:
- Reset then Start -> Running=1, SpeedSel=3 one cycle later, SelChg pulses once.
- 8 ScoreEvt pulses in RUN -> Level=4, SpeedSel=4, state HOLD. Exits to RUN after exactly 4 DivClk rising edges.
- 16 ScoreEvt pulses back-to-back inside one HOLD window -> pending set once. After the dwell, Level=5 and HOLD re-entered; final Level is 5, not 6.
- Pause high in HOLD after 2 ticks, 10 ticks while paused, Pause low -> SpeedSel=1 while paused. HOLD resumes and needs 2 more ticks to exit.
- DbgEn=1 with DbgSel=15 during RUN, then 8 ScoreEvt -> SpeedSel=15 throughout. On DbgEn=0, SpeedSel=Level=4.
- GameOver and Pause in the same cycle -> OVER, SpeedSel=0. Start -> IDLE; second Start -> RUN at Level 3. Rst low mid-HOLD -> outputs at reset values asynchronously.
